// File: rtl/rx_bit_deserialiser_if.sv
// rtl/rx_bit_deserialiser_if.sv - bit-level receive input and byte-level receive output bundle
interface rx_bit_deserialiser_if;
  logic       in_soc;
  logic       in_eoc;
  logic       in_data;
  logic       in_data_valid;
  logic       in_error;
  logic       out_soc;
  logic       out_eoc;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;
  logic       out_data_valid;
  logic       out_error;

  modport master (
    output in_soc, in_eoc, in_data, in_data_valid, in_error,
    input  out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error
  );

  modport slave (
    input  in_soc, in_eoc, in_data, in_data_valid, in_error,
    output out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error
  );
endinterface

// File: rtl/rx_bit_deserialiser.sv
// rtl/rx_bit_deserialiser.sv - LSB-first bit-to-byte assembler with trailing odd parity per byte
// Optional RX_PARITY_CHECK_EN: reject bytes whose odd parity fails instead of discarding the parity bit.
module rx_bit_deserialiser (
  input logic                  clk,
  input logic                  rst_n,
  rx_bit_deserialiser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       out_soc_q, out_soc_d;
  logic       out_eoc_q, out_eoc_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] out_data_bits_q, out_data_bits_d;
  logic       out_data_valid_q, out_data_valid_d;
  logic       out_error_q, out_error_d;
`ifdef RX_PARITY_CHECK_EN
  logic       par_q, par_d;
`endif

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    out_soc_d        = bus.in_soc;
    out_eoc_d        = 1'b0;
    out_data_d       = out_data_q;
    out_data_bits_d  = out_data_bits_q;
    out_data_valid_d = 1'b0;
    out_error_d      = 1'b0;
`ifdef RX_PARITY_CHECK_EN
    par_d            = par_q;
`endif

    // A start pulse wins in every state and silently abandons any frame in progress.
    if (bus.in_soc) begin
      state_d   = DATA;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
`ifdef RX_PARITY_CHECK_EN
      par_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        DATA: begin
          if (bus.in_error) begin
            out_error_d = 1'b1;
            out_eoc_d   = bus.in_eoc;
            state_d     = bus.in_eoc ? IDLE : DRAIN;
          end else if (bus.in_eoc) begin
            out_eoc_d = 1'b1;
            state_d   = IDLE;
            if (bit_cnt_q == 4'd8) begin
              out_error_d = 1'b1;
            end else if (bit_cnt_q != 4'd0) begin
              out_data_valid_d = 1'b1;
              out_data_d       = shift_q;
              out_data_bits_d  = bit_cnt_q[2:0];
            end
          end else if (bus.in_data_valid) begin
            if (bit_cnt_q == 4'd8) begin
              // Clearing here keeps stale high bits out of a later partial byte.
              bit_cnt_d = 4'd0;
              shift_d   = 8'h00;
`ifdef RX_PARITY_CHECK_EN
              par_d     = 1'b0;
              if (par_q ^ bus.in_data) begin
                out_data_valid_d = 1'b1;
                out_data_d       = shift_q;
                out_data_bits_d  = 3'd0;
              end else begin
                out_error_d = 1'b1;
                state_d     = DRAIN;
              end
`else
              out_data_valid_d = 1'b1;
              out_data_d       = shift_q;
              out_data_bits_d  = 3'd0;
`endif
            end else begin
              shift_d[bit_cnt_q[2:0]] = bus.in_data;
              bit_cnt_d               = bit_cnt_q + 4'd1;
`ifdef RX_PARITY_CHECK_EN
              par_d                   = par_q ^ bus.in_data;
`endif
            end
          end
        end
        DRAIN: begin
          if (bus.in_eoc) begin
            out_eoc_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bit_cnt_q        <= 4'd0;
      shift_q          <= 8'h00;
      out_soc_q        <= 1'b0;
      out_eoc_q        <= 1'b0;
      out_data_q       <= 8'h00;
      out_data_bits_q  <= 3'd0;
      out_data_valid_q <= 1'b0;
      out_error_q      <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      par_q            <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      out_soc_q        <= out_soc_d;
      out_eoc_q        <= out_eoc_d;
      out_data_q       <= out_data_d;
      out_data_bits_q  <= out_data_bits_d;
      out_data_valid_q <= out_data_valid_d;
      out_error_q      <= out_error_d;
`ifdef RX_PARITY_CHECK_EN
      par_q            <= par_d;
`endif
    end
  end

  assign bus.out_soc        = out_soc_q;
  assign bus.out_eoc        = out_eoc_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_data_bits  = out_data_bits_q;
  assign bus.out_data_valid = out_data_valid_q;
  assign bus.out_error      = out_error_q;
endmodule

// File: tb/tb_rx_bit_deserialiser.sv
// tb/tb_rx_bit_deserialiser.sv - randomized self-checking bench for rx_bit_deserialiser
module tb_rx_bit_deserialiser;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rx_bit_deserialiser_if bus ();
  rx_bit_deserialiser dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Stimulus vector per cycle: {soc, eoc, data, data_valid, error}
  localparam logic [4:0] SOC = 5'b10000;
  localparam logic [4:0] EOC = 5'b01000;
  localparam logic [4:0] ERR = 5'b00001;
  localparam logic [4:0] IDL = 5'b00000;

  logic [4:0] stim[$];

  // Reference model state: frame-level view of collected bits
  bit         m_act;
  bit         m_drain;
  logic       m_bits[$];
  logic [7:0] m_data;
  logic [2:0] m_nb;

  function automatic logic [4:0] bitv(input logic b);
    return {2'b00, b, 1'b1, 1'b0};
  endfunction

  function void add_bits(input logic [7:0] v, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      stim.push_back(bitv(v[i]));
      if (gaps) repeat ($urandom_range(0, 2)) stim.push_back({2'b00, 1'($urandom), 2'b00});
    end
  endfunction

  function automatic logic [14:0] obs();
    return {bus.out_soc, bus.out_eoc, bus.out_data_valid, bus.out_error,
            bus.out_data_bits, bus.out_data};
  endfunction

  task model_reset();
    m_act = 0;
    m_drain = 0;
    m_bits.delete();
    m_data = 8'h00;
    m_nb = 3'd0;
  endtask

  task model_step(input logic [4:0] v, output logic [14:0] e);
    logic soc, eoc, d, dv, err;
    logic es, ee, ev, er, pass;
    logic [7:0] byte_v;
    {soc, eoc, d, dv, err} = v;
    es = soc; ee = 0; ev = 0; er = 0;
    byte_v = 8'h00;
    foreach (m_bits[i]) byte_v = byte_v | (8'(m_bits[i]) << i);
    if (soc) begin
      m_act = 1; m_drain = 0; m_bits.delete();
    end else if (m_act) begin
      if (err) begin
        er = 1; m_act = 0;
        if (eoc) ee = 1; else m_drain = 1;
      end else if (eoc) begin
        ee = 1; m_act = 0;
        if (m_bits.size() == 8) er = 1;
        else if (m_bits.size() > 0) begin
          ev = 1; m_data = byte_v; m_nb = 3'(m_bits.size());
        end
      end else if (dv) begin
        if (m_bits.size() < 8) m_bits.push_back(d);
        else begin
          pass = 1'b1;
`ifdef RX_PARITY_CHECK_EN
          pass = ($countones({byte_v, d}) % 2) == 1;
`endif
          if (pass) begin
            ev = 1; m_data = byte_v; m_nb = 3'd0;
          end else begin
            er = 1; m_act = 0; m_drain = 1;
          end
          m_bits.delete();
        end
      end
    end else if (m_drain && eoc) begin
      ee = 1; m_drain = 0;
    end
    e = {es, ee, ev, er, m_nb, m_data};
  endtask

  task step(input logic [4:0] v, output logic [14:0] o, output logic [14:0] e);
    {bus.in_soc, bus.in_eoc, bus.in_data, bus.in_data_valid, bus.in_error} = v;
    model_step(v, e);
    @(posedge clk);
    #1;
    o = obs();
  endtask

  task test_reset();
    logic [14:0] o;
    {bus.in_soc, bus.in_eoc, bus.in_data, bus.in_data_valid, bus.in_error} = SOC;
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      o = obs();
      vectors++;
      if (o !== 15'h0) begin
        miscompares++;
        $display("FAIL reset_state: got %h want %h", o, 15'h0);
      end
    end
    {bus.in_soc, bus.in_eoc, bus.in_data, bus.in_data_valid, bus.in_error} = IDL;
    rst_n = 1'b1;
  endtask

  task test_full_bytes();
    logic [14:0] o, e;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'h93, 8, 1); stim.push_back(bitv(1'b0));
    add_bits(8'h20, 8, 1); stim.push_back(bitv(1'b0));
    stim.push_back(EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_bytes cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task test_short_frame();
    logic [14:0] o, e;
    int hits = 0;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'h26, 7, 1);
    stim.push_back(EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL short_frame cyc %0d: got %h want %h", i, o, e);
      end
      if (o[12]) begin
        hits++;
        vectors++;
        if (o !== {4'b0110, 3'd7, 8'h26}) begin
          miscompares++;
          $display("FAIL short_frame_byte: got %h want %h", o, {4'b0110, 3'd7, 8'h26});
        end
      end
    end
    vectors++;
    if (hits !== 1) begin
      miscompares++;
      $display("FAIL short_frame_count: got %0d want 1", hits);
    end
  endtask

  task test_parity();
    logic [14:0] o, e;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'h93, 8, 0); stim.push_back(bitv(1'b1));
    add_bits(8'h93, 8, 0); stim.push_back(bitv(1'b0));
    stim.push_back(EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL parity cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task test_error_drain();
    logic [14:0] o, e;
    int good = 0;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'h05, 3, 0);
    stim.push_back(ERR);
    add_bits(8'h0F, 4, 0);
    stim.push_back(EOC);
    stim.push_back(SOC);
    add_bits(8'h52, 8, 1); stim.push_back(bitv(1'b0));
    stim.push_back(EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL error_drain cyc %0d: got %h want %h", i, o, e);
      end
      if (o[12]) begin
        good++;
        vectors++;
        if (o[7:0] !== 8'h52 || o[10:8] !== 3'd0) begin
          miscompares++;
          $display("FAIL error_drain_byte: got %h want 52 bits 0", o);
        end
      end
    end
    vectors++;
    if (good !== 1) begin
      miscompares++;
      $display("FAIL error_drain_count: got %0d want 1", good);
    end
  endtask

  task test_missing_parity();
    logic [14:0] o, e;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'hFF, 8, 0);
    stim.push_back(EOC);
    stim.push_back(SOC);
    add_bits(8'hA5, 2, 0);
    stim.push_back(ERR | EOC);
    stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL missing_parity cyc %0d: got %h want %h", i, o, e);
      end
      if (i == 9) begin
        vectors++;
        if (o[14:11] !== 4'b0101) begin
          miscompares++;
          $display("FAIL missing_parity_flags: got %b want 0101", o[14:11]);
        end
      end
    end
  endtask

  task test_idle_ignored();
    logic [14:0] o, e;
    stim.delete();
    add_bits(8'h3C, 8, 1);
    stim.push_back(EOC); stim.push_back(ERR); stim.push_back(ERR | EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL idle_ignored cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task test_reset_midframe();
    logic [14:0] o, e;
    stim.delete();
    stim.push_back(SOC);
    add_bits(8'h1B, 5, 0);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, o, e);
      end
    end
    {bus.in_soc, bus.in_eoc, bus.in_data, bus.in_data_valid, bus.in_error} = bitv(1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    repeat (3) begin
      o = obs();
      vectors++;
      if (o !== 15'h0) begin
        miscompares++;
        $display("FAIL reset_mid_hold: got %h want %h", o, 15'h0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    stim.delete();
    add_bits(8'h77, 3, 0);
    stim.push_back(EOC);
    stim.push_back(SOC);
    add_bits(8'h50, 8, 1); stim.push_back(bitv(1'b1));
    stim.push_back(EOC); stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_post cyc %0d: got %h want %h", i, o, e);
      end
      if (o[12]) begin
        vectors++;
        if (o[7:0] !== 8'h50) begin
          miscompares++;
          $display("FAIL reset_mid_byte: got %h want 50", o[7:0]);
        end
      end
    end
  endtask

  task test_back_to_back();
    logic [14:0] o, e;
    stim.delete();
    for (int f = 0; f < 150; f++) begin
      int nb;
      int r;
      stim.push_back(SOC);
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        add_bits(8'($urandom), 8, 0);
        stim.push_back(bitv(1'($urandom)));
      end
      add_bits(8'($urandom), $urandom_range(0, 8), 0);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        stim.push_back(ERR);
        add_bits(8'($urandom), $urandom_range(0, 4), 0);
        stim.push_back(EOC);
      end else if (r == 1) begin
        stim.push_back(ERR | EOC);
      end else if (r != 2) begin
        stim.push_back(EOC);
      end
    end
    stim.push_back(IDL);
    foreach (stim[i]) begin
      step(stim[i], o, e);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  initial begin
    {bus.in_soc, bus.in_eoc, bus.in_data, bus.in_data_valid, bus.in_error} = IDL;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_full_bytes();
    test_short_frame();
    test_parity();
    test_error_drain();
    test_missing_parity();
    test_idle_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
